// File: rtl/rv32im_ifu_pkg.sv
// Shared widths, reset PC, FSM encodings and the buffered response entry
// for the rv32im instruction fetch unit.
package rv32im_ifu_pkg;

    localparam int          API_ADDR_WIDTH = 32;
    localparam int          API_DATA_WIDTH = 32;
    localparam logic [31:0] API_RESET_PC   = 32'h0000_0000;
    localparam int          IFU_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IFU_ST_BOOT  = 2'd0,
        IFU_ST_FETCH = 2'd1,
        IFU_ST_HALT  = 2'd2
    } ifu_state_e;

    // One returned instruction as it sits in the response FIFO
    typedef struct packed {
        logic [API_DATA_WIDTH-1:0] data;
        logic                      err;
        logic [API_ADDR_WIDTH-1:0] pc;
    } ifu_rsp_t;

    // Sequential fetch step; wraps naturally at the top of the address space
    function automatic logic [API_ADDR_WIDTH-1:0] ifu_pc_inc(input logic [API_ADDR_WIDTH-1:0] pc);
        return pc + API_ADDR_WIDTH'(4);
    endfunction

endpackage

// File: rtl/rv32im_ifu_fifo.sv
// Small synchronous FIFO with flush and occupancy count. A push into a
// full FIFO is only accepted when a pop happens in the same cycle.
module rv32im_ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push_ok, pop_ok;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem[rd_ptr];
    assign count_o = count;

    // Storage, pointers and count; flush empties without touching storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/rv32im_ifu.sv
// Instruction fetch unit: owns the PC, issues credit-limited in-order fetches,
// buffers responses for decode and handles branch redirects by flushing
// buffered state and dropping responses still in flight.
module rv32im_ifu
    import rv32im_ifu_pkg::*;
#(
    parameter logic [API_ADDR_WIDTH-1:0] RESET_PC   = API_RESET_PC,
    parameter int                        FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      redirect_i,
    input  logic [API_ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                      imem_req_valid_o,
    input  logic                      imem_req_ready_i,
    output logic [API_ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                      imem_rsp_valid_i,
    input  logic [API_DATA_WIDTH-1:0] imem_rsp_data_i,
    input  logic                      imem_rsp_err_i,
    output logic                      inst_valid_o,
    input  logic                      inst_ready_i,
    output logic [API_DATA_WIDTH-1:0] inst_o,
    output logic [API_ADDR_WIDTH-1:0] inst_pc_o,
    output logic                      inst_err_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e                state, next_state;
    logic [API_ADDR_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]             outstanding, drop_cnt;

    logic                      redir, credit_ok, req_fire;
    logic                      rsp_accept, rsp_keep, inst_pop;
    logic [CW:0]               in_use;

    logic [API_ADDR_WIDTH-1:0] pcq_head;
    logic [CW-1:0]             pcq_count, rsp_count;
    logic                      pcq_empty, pcq_full, rsp_empty, rsp_full;
    ifu_rsp_t                  rsp_in, rsp_head;

    // Redirects only matter once the unit has left BOOT
    assign redir      = redirect_i && (state != IFU_ST_BOOT);
    // Count buffered plus in-flight words so every response has a slot
    assign in_use     = {1'b0, outstanding} + {1'b0, rsp_count};
    assign credit_ok  = in_use < (CW+1)'(FIFO_DEPTH);

    assign imem_req_valid_o = (state == IFU_ST_FETCH) && !redirect_i && credit_ok;
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // A response with nothing outstanding is illegal and simply ignored
    assign rsp_accept = imem_rsp_valid_i && (outstanding != '0);
    assign rsp_keep   = rsp_accept && (drop_cnt == '0) && !redir;

    assign inst_valid_o = !rsp_empty && !redirect_i;
    assign inst_pop     = inst_valid_o && inst_ready_i;
    assign inst_o       = rsp_head.data;
    assign inst_pc_o    = rsp_head.pc;
    assign inst_err_o   = rsp_head.err;

    assign rsp_in = '{data: imem_rsp_data_i, err: imem_rsp_err_i, pc: pcq_head};

    // PCs of live (not-to-be-dropped) requests, in issue order
    rv32im_ifu_fifo #(.WIDTH(API_ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_pc_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redir),
        .push_i  (req_fire),
        .wdata_i (fetch_pc),
        .pop_i   (rsp_keep),
        .rdata_o (pcq_head),
        .count_o (pcq_count),
        .empty_o (pcq_empty),
        .full_o  (pcq_full)
    );

    // Returned instructions waiting for decode
    rv32im_ifu_fifo #(.WIDTH($bits(ifu_rsp_t)), .DEPTH(FIFO_DEPTH)) u_rsp_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redir),
        .push_i  (rsp_keep),
        .wdata_i (rsp_in),
        .pop_i   (inst_pop),
        .rdata_o (rsp_head),
        .count_o (rsp_count),
        .empty_o (rsp_empty),
        .full_o  (rsp_full)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IFU_ST_BOOT;
        else         state <= next_state;
    end

    // FSM next state: halt once a faulting instruction reaches decode
    always_comb begin
        next_state = state;
        case (state)
            IFU_ST_BOOT:  next_state = IFU_ST_FETCH;
            IFU_ST_FETCH: if (!redir && inst_pop && rsp_head.err) next_state = IFU_ST_HALT;
            IFU_ST_HALT:  if (redir) next_state = IFU_ST_FETCH;
            default:      next_state = IFU_ST_BOOT;
        endcase
    end

    // PC and in-flight bookkeeping; on redirect everything in flight becomes drop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redir) begin
            fetch_pc    <= redirect_pc_i & ~API_ADDR_WIDTH'(3);
            drop_cnt    <= outstanding - CW'(rsp_accept);
            outstanding <= outstanding - CW'(rsp_accept);
        end else begin
            if (req_fire) fetch_pc <= ifu_pc_inc(fetch_pc);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
            if (rsp_accept && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        end
    end

    a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rsp_valid_i |-> (outstanding != '0));
    a_pcq_tracks:   assert property (@(posedge clk_i) disable iff (!rst_ni)
        pcq_count == (outstanding - drop_cnt));
    a_pcq_room:     assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_fire |-> !pcq_full);
    a_pcq_has_pc:   assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_keep |-> !pcq_empty);
    a_rsp_room:     assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_keep |-> !(rsp_full && !inst_pop));

endmodule

// File: tb/tb_rv32im_ifu.sv
// Directed bench for rv32im_ifu with an in-order memory model of programmable
// latency. Memory returns data = addr ^ 0x13, err when addr == err_addr.
module tb_rv32im_ifu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b1;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        imem_rsp_err_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b1;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_err_o;

    rv32im_ifu dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .inst_o           (inst_o),
        .inst_pc_o        (inst_pc_o),
        .inst_err_o       (inst_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; int due; } mq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } ent_t;

    mq_t         mq[$];
    logic [31:0] req_log[$];
    ent_t        inst_log[$];
    int          edge_n = 0;
    int          mem_lat = 1;
    logic [31:0] err_addr = 32'h1;
    int          n_tests = 0;
    int          n_fail = 0;

    // Memory model: accepts on the edge, answers mem_lat cycles later, in order
    always @(posedge clk_i) begin
        mq_t m;
        edge_n++;
        if (rst_ni && imem_req_valid_o && imem_req_ready_i)
            mq.push_back('{imem_req_addr_o, edge_n + mem_lat - 1});
        #1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        if (mq.size() > 0 && mq[0].due <= edge_n) begin
            m = mq.pop_front();
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = m.addr ^ 32'h13;
            imem_rsp_err_i   = (m.addr == err_addr);
        end
    end

    // Handshake monitor
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (imem_req_valid_o && imem_req_ready_i) req_log.push_back(imem_req_addr_o);
            if (inst_valid_o && inst_ready_i) inst_log.push_back('{inst_pc_o, inst_o, inst_err_o});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        redirect_i = 1'b0;
        req_log.delete();
        inst_log.delete();
        tick(3);
        rst_ni = 1'b1;
    endtask

    initial begin
        bit found;
        // ---- reset state
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid_o), 0);
        chk("rst_req_addr", imem_req_addr_o, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid_o), 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_inst_pc", inst_pc_o, 0);
        chk("rst_inst_err", 32'(inst_err_o), 0);

        // ---- startup latency and streaming
        do_reset();
        tick(1); #1;
        chk("t1_c0_valid", 32'(imem_req_valid_o), 1);
        chk("t1_c0_addr", imem_req_addr_o, 32'h0);
        chk("t1_c0_ivalid", 32'(inst_valid_o), 0);
        tick(1); #1;
        chk("t1_c1_addr", imem_req_addr_o, 32'h4);
        chk("t1_c1_ivalid", 32'(inst_valid_o), 0);
        tick(1); #1;
        chk("t1_c2_ivalid", 32'(inst_valid_o), 1);
        chk("t1_c2_pc", inst_pc_o, 32'h0);
        chk("t1_c2_inst", inst_o, 32'h13);
        chk("t1_c2_req_valid", 32'(imem_req_valid_o), 0);
        tick(1); #1;
        chk("t1_c3_pc", inst_pc_o, 32'h4);
        chk("t1_c3_addr", imem_req_addr_o, 32'h8);
        tick(10);
        chk("t1_req_n", 32'(req_log.size() >= 4), 1);
        chk("t1_req3", req_log[3], 32'hC);
        chk("t1_inst_n", 32'(inst_log.size() >= 3), 1);
        chk("t1_inst2_pc", inst_log[2].pc, 32'h8);
        chk("t1_inst2_data", inst_log[2].inst, 32'h1B);

        // ---- decode back-pressure fills the buffer
        inst_ready_i = 1'b0;
        do_reset();
        tick(10); #1;
        chk("t2_req_n", 32'(req_log.size()), 2);
        chk("t2_req0", req_log[0], 32'h0);
        chk("t2_req1", req_log[1], 32'h4);
        chk("t2_req_valid", 32'(imem_req_valid_o), 0);
        chk("t2_ivalid", 32'(inst_valid_o), 1);
        chk("t2_head_pc", inst_pc_o, 32'h0);
        inst_ready_i = 1'b1;
        tick(6);
        chk("t2_inst_n", 32'(inst_log.size() >= 2), 1);
        chk("t2_drain0", inst_log[0].pc, 32'h0);
        chk("t2_drain1", inst_log[1].pc, 32'h4);
        chk("t2_drain1_data", inst_log[1].inst, 32'h17);
        chk("t2_resume", req_log[2], 32'h8);

        // ---- memory stall holds the address
        imem_req_ready_i = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1); #1;
            chk("t3_stall_valid", 32'(imem_req_valid_o), 1);
            chk("t3_stall_addr", imem_req_addr_o, 32'h0);
        end
        imem_req_ready_i = 1'b1;
        tick(1); #1;
        chk("t3_advance", imem_req_addr_o, 32'h4);

        // ---- redirect drops in-flight responses
        mem_lat = 3;
        do_reset();
        tick(1);
        redirect_i = 1'b1; redirect_pc_i = 32'h10;
        #1 chk("t4_withdraw", 32'(imem_req_valid_o), 0);
        tick(1);
        redirect_i = 1'b0;
        tick(2);
        redirect_i = 1'b1; redirect_pc_i = 32'h103;
        #1;
        chk("t4_redir_req_valid", 32'(imem_req_valid_o), 0);
        chk("t4_redir_ivalid", 32'(inst_valid_o), 0);
        chk("t4_req_n", 32'(req_log.size()), 2);
        chk("t4_req0", req_log[0], 32'h10);
        chk("t4_req1", req_log[1], 32'h14);
        tick(1);
        redirect_i = 1'b0;
        tick(14);
        chk("t4_new_addr", req_log[2], 32'h100);
        chk("t4_inst_n", 32'(inst_log.size() >= 1), 1);
        chk("t4_first_pc", inst_log[0].pc, 32'h100);
        chk("t4_first_data", inst_log[0].inst, 32'h113);

        // ---- fault halts fetch, redirect resumes
        mem_lat = 1;
        err_addr = 32'h8;
        do_reset();
        tick(12); #1;
        chk("t5_req_n", 32'(req_log.size()), 4);
        chk("t5_req_valid", 32'(imem_req_valid_o), 0);
        chk("t5_inst_n", 32'(inst_log.size()), 4);
        chk("t5_ok_err", 32'(inst_log[1].err), 0);
        chk("t5_err_pc", inst_log[2].pc, 32'h8);
        chk("t5_err_flag", 32'(inst_log[2].err), 1);
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        tick(1);
        redirect_i = 1'b0;
        err_addr = 32'h1;
        tick(6);
        chk("t5_resume_addr", req_log[4], 32'h200);
        chk("t5_resume_pc", inst_log[4].pc, 32'h200);
        chk("t5_resume_err", 32'(inst_log[4].err), 0);

        // ---- address wrap (low redirect bits ignored)
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        begin
            int n;
            n = req_log.size();
            tick(1);
            redirect_i = 1'b0;
            tick(6);
            chk("t6_top", req_log[n], 32'hFFFF_FFFC);
            chk("t6_wrap", req_log[n+1], 32'h0);
        end

        // ---- reset mid-stream with a request in flight
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1); #1;
            if (imem_req_valid_o && imem_req_ready_i) found = 1'b1;
        end
        chk("t7_fire_seen", 32'(found), 1);
        tick(1);
        rst_ni = 1'b0;
        #1;
        chk("t7_req_valid", 32'(imem_req_valid_o), 0);
        chk("t7_ivalid", 32'(inst_valid_o), 0);
        chk("t7_inst", inst_o, 0);
        chk("t7_pc", inst_pc_o, 0);
        chk("t7_err", 32'(inst_err_o), 0);
        req_log.delete();
        inst_log.delete();
        tick(3);
        mem_lat = 1;
        rst_ni = 1'b1;
        tick(8);
        chk("t7_req_n", 32'(req_log.size() >= 1), 1);
        chk("t7_restart", req_log[0], 32'h0);
        chk("t7_inst_n", 32'(inst_log.size() >= 1), 1);
        chk("t7_first_pc", inst_log[0].pc, 32'h0);
        chk("t7_first_data", inst_log[0].inst, 32'h13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
